// File: rtl/branch_tag_ctrl.sv
// Branch tag allocator: hands out free tags to dispatched branches, tracks allocation
// order in an age FIFO so correct-path frees can be checked, and flushes on mispredict.
module branch_tag_ctrl #(
    parameter int TAG_NUM = 4,
    parameter int TAG_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               allocReq,
    output logic               allocGrant,
    output logic [TAG_W-1:0]   allocNum,
    output logic [TAG_NUM-1:0] depMask,
    output logic               full,
    input  logic               bFreeEn,
    input  logic [TAG_W-1:0]   bFreeNum,
    input  logic               misTaken,
    output logic               orderErr,
    output logic [TAG_W:0]     count
);

    logic [TAG_NUM-1:0]            mask_q, mask_d;
    logic [TAG_NUM-1:0][TAG_W-1:0] fifo_q;
    logic [TAG_W-1:0]              head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]                count_q, count_d;
    logic                          orderErr_q, orderErr_d;
    logic [TAG_W-1:0]              free_idx;
    logic [TAG_NUM-1:0]            free_oh;
    logic                          valid_free;

    // Lowest-index idle tag; naturally 0 when every tag is busy.
    always_comb begin
        free_idx = '0;
        for (int i = TAG_NUM - 1; i >= 0; i--) begin
            if (!mask_q[i]) free_idx = TAG_W'(i);
        end
    end

    assign full       = (count_q == (TAG_W+1)'(TAG_NUM));
    assign allocGrant = allocReq & ~full & ~misTaken;
    assign allocNum   = free_idx;
    assign free_oh    = bFreeEn ? (TAG_NUM'(1) << bFreeNum) : '0;
    // A tag freed this cycle is dropped so new instructions never wait on a missed free pulse.
    assign depMask    = mask_q & ~free_oh;
    assign count      = count_q;
    assign orderErr   = orderErr_q;

    // Frees must hit a busy tag that is also the oldest outstanding one.
    assign valid_free = bFreeEn & mask_q[bFreeNum] & (fifo_q[head_q] == bFreeNum);

    always_comb begin
        mask_d     = mask_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        orderErr_d = orderErr_q;
        if (misTaken) begin
            mask_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (allocGrant) begin
                mask_d[allocNum] = 1'b1;
                tail_d           = tail_q + 1'b1;
            end
            if (valid_free) begin
                mask_d[bFreeNum] = 1'b0;
                head_d           = head_q + 1'b1;
            end else if (bFreeEn) begin
                orderErr_d = 1'b1;
            end
            count_d = count_q + (TAG_W+1)'(allocGrant) - (TAG_W+1)'(valid_free);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q     <= '0;
            fifo_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            orderErr_q <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            orderErr_q <= orderErr_d;
            if (allocGrant) fifo_q[tail_q] <= allocNum;
        end
    end

endmodule

// File: tb/tb_branch_tag_ctrl.sv
// Directed bench for branch_tag_ctrl: a per-cycle vector table plus hand-written
// sequences for asynchronous reset and FIFO wrap-around.
module tb_branch_tag_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       allocReq, bFreeEn, misTaken;
    logic [1:0] bFreeNum;
    logic       allocGrant, full, orderErr;
    logic [1:0] allocNum;
    logic [3:0] depMask;
    logic [2:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    branch_tag_ctrl #(.TAG_NUM(4), .TAG_W(2)) dut (
        .clk(clk), .rst(rst), .allocReq(allocReq), .allocGrant(allocGrant),
        .allocNum(allocNum), .depMask(depMask), .full(full), .bFreeEn(bFreeEn),
        .bFreeNum(bFreeNum), .misTaken(misTaken), .orderErr(orderErr), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       aR, fE;
        logic [1:0] fN;
        logic       mT;
        logic       gnt;
        logic [1:0] num;
        logic [3:0] dep;
        logic       full;
        logic [2:0] cnt;
        logic       oe;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t v(input int aR, fE, fN, mT, gnt, num, dep, fl, cnt, oe);
        vec_t r;
        r.aR = 1'(aR);  r.fE = 1'(fE);   r.fN = 2'(fN);  r.mT = 1'(mT);
        r.gnt = 1'(gnt); r.num = 2'(num); r.dep = 4'(dep); r.full = 1'(fl);
        r.cnt = 3'(cnt); r.oe = 1'(oe);
        return r;
    endfunction

    task automatic check(input string nm, input int row, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", nm, row, act, exp);
        end
    endtask

    // Drive inputs after the falling edge; outputs settle well before the next rising edge.
    task automatic drive(input int aR, fE, fN, mT);
        @(negedge clk);
        allocReq = 1'(aR); bFreeEn = 1'(fE); bFreeNum = 2'(fN); misTaken = 1'(mT);
        #1;
    endtask

    task automatic check_all(input int row, input vec_t e);
        check("allocGrant", row, int'(allocGrant), int'(e.gnt));
        check("allocNum",   row, int'(allocNum),   int'(e.num));
        check("depMask",    row, int'(depMask),    int'(e.dep));
        check("full",       row, int'(full),       int'(e.full));
        check("count",      row, int'(count),      int'(e.cnt));
        check("orderErr",   row, int'(orderErr),   int'(e.oe));
    endtask

    initial begin
        //            aR fE fN mT | gnt num dep     full cnt oe
        tbl[0]  = v(1, 0, 0, 0,   1, 0, 4'b0000, 0, 0, 0);
        tbl[1]  = v(1, 0, 0, 0,   1, 1, 4'b0001, 0, 1, 0);
        tbl[2]  = v(1, 0, 0, 0,   1, 2, 4'b0011, 0, 2, 0);
        tbl[3]  = v(1, 0, 0, 0,   1, 3, 4'b0111, 0, 3, 0);
        tbl[4]  = v(1, 0, 0, 0,   0, 0, 4'b1111, 1, 4, 0);
        tbl[5]  = v(1, 1, 0, 0,   0, 0, 4'b1110, 1, 4, 0);
        tbl[6]  = v(1, 0, 0, 0,   1, 0, 4'b1110, 0, 3, 0);
        tbl[7]  = v(0, 1, 1, 0,   0, 0, 4'b1101, 1, 4, 0);
        tbl[8]  = v(0, 1, 2, 0,   0, 1, 4'b1001, 0, 3, 0);
        tbl[9]  = v(0, 1, 3, 0,   0, 1, 4'b0001, 0, 2, 0);
        tbl[10] = v(0, 1, 0, 0,   0, 1, 4'b0000, 0, 1, 0);
        tbl[11] = v(0, 0, 0, 0,   0, 0, 4'b0000, 0, 0, 0);
        tbl[12] = v(1, 0, 0, 0,   1, 0, 4'b0000, 0, 0, 0);
        tbl[13] = v(1, 0, 0, 0,   1, 1, 4'b0001, 0, 1, 0);
        tbl[14] = v(1, 0, 0, 0,   1, 2, 4'b0011, 0, 2, 0);
        tbl[15] = v(1, 0, 0, 1,   0, 3, 4'b0111, 0, 3, 0);
        tbl[16] = v(1, 0, 0, 0,   1, 0, 4'b0000, 0, 0, 0);
        tbl[17] = v(1, 0, 0, 0,   1, 1, 4'b0001, 0, 1, 0);
        tbl[18] = v(0, 1, 1, 0,   0, 2, 4'b0001, 0, 2, 0);
        tbl[19] = v(0, 1, 3, 0,   0, 2, 4'b0011, 0, 2, 1);
        tbl[20] = v(0, 0, 0, 0,   0, 2, 4'b0011, 0, 2, 1);
        tbl[21] = v(0, 0, 0, 1,   0, 2, 4'b0011, 0, 2, 1);
        tbl[22] = v(0, 0, 0, 0,   0, 0, 4'b0000, 0, 0, 1);

        rst = 1'b0; allocReq = 1'b0; bFreeEn = 1'b0; bFreeNum = 2'd0; misTaken = 1'b0;
        #2;
        check("rst.count",   100, int'(count),      0);
        check("rst.depMask", 100, int'(depMask),    0);
        check("rst.full",    100, int'(full),       0);
        check("rst.grant",   100, int'(allocGrant), 0);
        check("rst.allocNum",100, int'(allocNum),   0);
        check("rst.orderErr",100, int'(orderErr),   0);
        @(negedge clk); rst = 1'b1;

        foreach (tbl[i]) begin
            drive(int'(tbl[i].aR), int'(tbl[i].fE), int'(tbl[i].fN), int'(tbl[i].mT));
            check_all(i, tbl[i]);
        end

        // Async reset mid-run with three tags outstanding (orderErr is still set from the table).
        drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("pre_rst.count", 200, int'(count), 3);
        @(posedge clk); #2;
        rst = 1'b0; #1;
        check("async.count",    201, int'(count),      0);
        check("async.depMask",  201, int'(depMask),    0);
        check("async.full",     201, int'(full),       0);
        check("async.grant",    201, int'(allocGrant), 0);
        check("async.orderErr", 201, int'(orderErr),   0);
        @(negedge clk); rst = 1'b1;

        // Wrap: alloc 0..3, free 0,1, realloc 0 then 1; frees then follow 2,3,0,1.
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0);
            check("wrap.alloc", 300 + k, int'(allocNum), k);
        end
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        drive(1, 0, 0, 0);
        check("wrap.realloc0", 310, int'(allocNum), 0);
        check("wrap.count2",   310, int'(count),    2);
        drive(1, 0, 0, 0);
        check("wrap.realloc1", 311, int'(allocNum), 1);
        check("wrap.dep",      311, int'(depMask),  4'b1101);
        drive(0, 0, 0, 0);
        check("wrap.full",     312, int'(full),     1);
        drive(0, 1, 2, 0);
        drive(0, 1, 3, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 0, 0, 0);
        check("wrap.count0",   313, int'(count),    0);
        check("wrap.orderErr", 313, int'(orderErr), 0);
        check("wrap.depMask",  313, int'(depMask),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
